// File: rtl/in_dev_pkg.sv
// Shared types and width helpers for the in_device_channel slice.
package in_dev_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        LATCH        = 2'd1,
        PRESENT      = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_e;

    localparam int unsigned DEFAULT_DATA_W = 32;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/in_device_channel_key_debouncer.sv
// Synchronizer plus debounce filter for an active-low push-button.
// Provides the accepted level, one-cycle rise/fall pulses and a released flag.
module key_debouncer
    import in_dev_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic level,
    output logic rise,
    output logic fall,
    output logic released
);

    localparam int unsigned CNT_W   = cnt_w(DEBOUNCE_CYCLES);
    localparam int unsigned FLUSH_W = cnt_w(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FLUSH_W-1:0]     flush_q, flush_d;
    logic                   level_q, level_d;
    logic                   prev_q;
    logic                   released_q, released_d;
    logic                   key_s;
    logic                   flush_done;

    assign key_s      = ~sync_q[SYNC_STAGES-1];
    assign flush_done = (flush_q == FLUSH_W'(SYNC_STAGES));

    always_comb begin
        sync_d[0] = key_n;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        level_d    = level_q;
        flush_d    = flush_q;
        released_d = released_q;
        if (key_s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = key_s;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        if (!flush_done) begin
            flush_d = flush_q + 1'b1;
        end
        // Only trust a "released" reading once the reset-valued sync flops have flushed.
        if (flush_done && !key_s) begin
            released_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '1;
            cnt_q      <= '0;
            flush_q    <= '0;
            level_q    <= 1'b0;
            prev_q     <= 1'b0;
            released_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            level_q    <= level_d;
            prev_q     <= level_q;
            released_q <= released_d;
        end
    end

    assign level    = level_q;
    assign rise     = level_q & ~prev_q;
    assign fall     = ~level_q & prev_q;
    assign released = released_q;

endmodule

// File: rtl/in_device_channel.sv
// Debounced push-button input channel presenting a latched switch word with an enter_in strobe.
// Optional auto-repeat while held: define IN_DEVICE_CHANNEL_AUTOREPEAT_EN.
module in_device_channel
    import in_dev_pkg::*;
#(
    parameter int unsigned DATA_W          = DEFAULT_DATA_W,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned HOLD_CYCLES     = 4,
    parameter int unsigned REPEAT_CYCLES   = 25000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_n,
    input  logic [DATA_W-1:0] sw,
    output logic [DATA_W-1:0] dev_in,
    output logic              enter_in,
    output logic              busy
);

    localparam int unsigned HOLD_W = cnt_w(HOLD_CYCLES);

    if (HOLD_CYCLES < 2 || SYNC_STAGES < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("in_device_channel: parameter out of range");
    end

    state_e                               state_q, state_d;
    logic [HOLD_W-1:0]                    hold_q, hold_d;
    logic [DATA_W-1:0]                    data_q, data_d;
    logic                                 enter_q, enter_d;
    logic [SYNC_STAGES-1:0][DATA_W-1:0]   sw_sync_q, sw_sync_d;
    logic                                 key_level, key_rise, key_fall, key_released;

`ifdef IN_DEVICE_CHANNEL_AUTOREPEAT_EN
    localparam int unsigned REP_W = cnt_w(REPEAT_CYCLES);
    logic [REP_W-1:0] rep_q, rep_d;
`endif

    key_debouncer #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_n    (key_n),
        .level    (key_level),
        .rise     (key_rise),
        .fall     (key_fall),
        .released (key_released)
    );

    always_comb begin
        sw_sync_d[0] = sw;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sw_sync_d[i] = sw_sync_q[i-1];
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        data_d  = data_q;
`ifdef IN_DEVICE_CHANNEL_AUTOREPEAT_EN
        rep_d   = rep_q;
`endif
        case (state_q)
            IDLE: begin
                if (key_rise && key_released) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                data_d  = sw_sync_q[SYNC_STAGES-1];
                hold_d  = '0;
                state_d = PRESENT;
            end
            PRESENT: begin
                if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    hold_d  = '0;
                    // A release already accepted during the strobe skips the wait.
                    state_d = key_level ? WAIT_RELEASE : IDLE;
`ifdef IN_DEVICE_CHANNEL_AUTOREPEAT_EN
                    rep_d   = '0;
`endif
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            WAIT_RELEASE: begin
                if (key_fall) begin
                    state_d = IDLE;
`ifdef IN_DEVICE_CHANNEL_AUTOREPEAT_EN
                end else if (key_level) begin
                    if (rep_q == REP_W'(REPEAT_CYCLES - 1)) begin
                        rep_d   = '0;
                        state_d = LATCH;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        enter_d = (state_d == PRESENT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            data_q    <= '0;
            enter_q   <= 1'b0;
            sw_sync_q <= '0;
`ifdef IN_DEVICE_CHANNEL_AUTOREPEAT_EN
            rep_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            data_q    <= data_d;
            enter_q   <= enter_d;
            sw_sync_q <= sw_sync_d;
`ifdef IN_DEVICE_CHANNEL_AUTOREPEAT_EN
            rep_q     <= rep_d;
`endif
        end
    end

    assign dev_in   = data_q;
    assign enter_in = enter_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_in_device_channel.sv
// Self-checking bench for in_device_channel; pulses are scored against an expected-presentation queue.
`timescale 1ns/1ps
module tb_in_device_channel;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SYNC   = 2;
    localparam int unsigned DEB    = 8;
    localparam int unsigned HOLD   = 4;
    localparam int unsigned REP    = 20;
    localparam int          LAT    = SYNC + DEB + 2;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                start;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              key_n = 1'b1;
    logic [DATA_W-1:0] sw = '0;
    logic [DATA_W-1:0] dev_in;
    logic              enter_in;
    logic              busy;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    exp_t exp_q[$];

    in_device_channel #(
        .DATA_W          (DATA_W),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_n    (key_n),
        .sw       (sw),
        .dev_in   (dev_in),
        .enter_in (enter_in),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: at the end of each enter_in pulse, pop the expected presentation and compare.
    task automatic monitor();
        bit                in_pulse = 0;
        logic [DATA_W-1:0] cur_data = '0;
        int                cur_start = 0;
        int                cur_width = 0;
        bit                cur_stable = 1;
        exp_t              e;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                in_pulse = 0;
            end else if (enter_in === 1'b1) begin
                if (!in_pulse) begin
                    in_pulse   = 1;
                    cur_data   = dev_in;
                    cur_start  = cyc;
                    cur_width  = 0;
                    cur_stable = 1;
                end
                cur_width++;
                if (dev_in !== cur_data) cur_stable = 0;
            end else if (in_pulse) begin
                in_pulse = 0;
                pulses++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: got pulse with data %h at cycle %0d, expected none", cur_data, cur_start);
                end else begin
                    e = exp_q.pop_front();
                    if (cur_data !== e.data) begin
                        errors++;
                        $display("FAIL pulse_data: got %h expected %h", cur_data, e.data);
                    end
                    checks++;
                    if (cur_width != HOLD) begin
                        errors++;
                        $display("FAIL pulse_width: got %0d expected %0d", cur_width, HOLD);
                    end
                    checks++;
                    if (!cur_stable) begin
                        errors++;
                        $display("FAIL pulse_stable: got dev_in changing during strobe, expected stable %h", cur_data);
                    end
                    if (e.start >= 0) begin
                        checks++;
                        if (cur_start != e.start) begin
                            errors++;
                            $display("FAIL pulse_start: got cycle %0d expected cycle %0d", cur_start, e.start);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        key_n = 1'b1;
        sw    = 32'h0000_00FF;
        tick(3);
        checks++;
        if (dev_in !== '0 || enter_in !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got dev_in=%h enter_in=%b busy=%b expected 0/0/0", dev_in, enter_in, busy);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (dev_in !== '0 || enter_in !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset: got dev_in=%h enter_in=%b expected 0/0 at clk %0d", dev_in, enter_in, i);
            end
        end
        tick(1);
    endtask

    task automatic test_clean_press();
        int base;
        sw = 32'hDEAD_BEEF;
        tick(5);
        base = pulses;
        exp_q.push_back('{32'hDEAD_BEEF, cyc + LAT});
        key_n = 1'b0;
        tick(40);
        key_n = 1'b1;
        tick(30);
        checks++;
        if (pulses - base != 1) begin
            errors++;
            $display("FAIL clean_press_count: got %0d pulses expected 1", pulses - base);
        end
        checks++;
        if (dev_in !== 32'hDEAD_BEEF || busy !== 1'b0) begin
            errors++;
            $display("FAIL clean_press_hold: got dev_in=%h busy=%b expected deadbeef/0", dev_in, busy);
        end
    endtask

    task automatic test_bounce();
        int base;
        sw = 32'hA5A5_0001;
        tick(4);
        checks++;
        if (dev_in !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL dev_in_held_until_press: got %h expected deadbeef", dev_in);
        end
        base = pulses;
        exp_q.push_back('{32'hA5A5_0001, -1});
        for (int i = 0; i < 5; i++) begin
            key_n = 1'b0;
            tick(3);
            key_n = 1'b1;
            tick(3);
        end
        key_n = 1'b0;
        tick(30);
        key_n = 1'b1;
        tick(30);
        checks++;
        if (pulses - base != 1) begin
            errors++;
            $display("FAIL bounce_count: got %0d pulses expected 1", pulses - base);
        end
    endtask

    task automatic test_hold_sw_change();
        int base;
        sw = 32'hCAFE_0001;
        tick(4);
        base = pulses;
        exp_q.push_back('{32'hCAFE_0001, cyc + LAT});
        key_n = 1'b0;
        tick(20);
        sw = 32'h1234_5678;
        tick(980);
        checks++;
        if (pulses - base != 1 || dev_in !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL long_hold: got %0d pulses dev_in=%h expected 1 pulse dev_in=cafe0001", pulses - base, dev_in);
        end
        key_n = 1'b1;
        tick(30);
        exp_q.push_back('{32'h1234_5678, cyc + LAT});
        key_n = 1'b0;
        tick(30);
        key_n = 1'b1;
        tick(30);
        checks++;
        if (pulses - base != 2 || dev_in !== 32'h1234_5678) begin
            errors++;
            $display("FAIL repress_after_hold: got %0d pulses dev_in=%h expected 2 pulses dev_in=12345678", pulses - base, dev_in);
        end
    endtask

    task automatic test_reset_mid_present();
        int  base;
        bit  seen = 0;
        sw = 32'h0BAD_F00D;
        tick(4);
        exp_q.push_back('{32'h0BAD_F00D, cyc + LAT});
        key_n = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (enter_in === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL present_timeout: got no enter_in within 100 clks, expected a strobe");
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (enter_in !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_drop: got enter_in=%b busy=%b expected 0/0", enter_in, busy);
        end
        @(negedge clk);
        exp_q.delete();
        tick(3);
        base = pulses;
        rst_n = 1'b1;
        tick(60);
        checks++;
        if (pulses != base || busy !== 1'b0) begin
            errors++;
            $display("FAIL held_after_reset: got %0d pulses busy=%b expected 0 pulses busy=0", pulses - base, busy);
        end
        key_n = 1'b1;
        tick(30);
        checks++;
        if (pulses != base) begin
            errors++;
            $display("FAIL release_after_reset: got %0d pulses expected 0", pulses - base);
        end
        sw = 32'h7777_0007;
        tick(4);
        exp_q.push_back('{32'h7777_0007, cyc + LAT});
        key_n = 1'b0;
        tick(30);
        key_n = 1'b1;
        tick(30);
        checks++;
        if (pulses - base != 1 || dev_in !== 32'h7777_0007) begin
            errors++;
            $display("FAIL new_press_after_reset: got %0d pulses dev_in=%h expected 1 pulse dev_in=77770007", pulses - base, dev_in);
        end
    endtask

`ifdef IN_DEVICE_CHANNEL_AUTOREPEAT_EN
    task automatic test_autorepeat();
        int base;
        int t0;
        sw = 32'h3C3C_3C3C;
        tick(4);
        base = pulses;
        t0   = cyc;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back('{32'h3C3C_3C3C, t0 + LAT + k * int'(REP + 1 + HOLD)});
        end
        key_n = 1'b0;
        tick(95);
        key_n = 1'b1;
        tick(40);
        checks++;
        if (pulses - base != 4) begin
            errors++;
            $display("FAIL autorepeat_count: got %0d pulses expected 4", pulses - base);
        end
    endtask
`endif

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold_sw_change();
        test_reset_mid_present();
`ifdef IN_DEVICE_CHANNEL_AUTOREPEAT_EN
        test_autorepeat();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: got %0d unmatched presentations expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
